// File: rtl/vector_pkg.sv
// Shared types for the vector-list sequencer: ROM entry layout, entry kinds,
// sequencer states and the entry decode.
package vector_pkg;

   localparam int XY_WIDTH = 8;

   typedef struct packed {
      logic [XY_WIDTH-1:0] x;
      logic [XY_WIDTH-1:0] y;
      logic                line;
      logic                pos;
   } vec_entry_t;

   typedef enum logic [1:0] {
      VEC_INVALID,
      VEC_MOVE,
      VEC_DRAW,
      VEC_END
   } vec_kind_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE
   } seq_state_t;

   // 00 is what an unprogrammed ROM location reads back as.
   function automatic vec_kind_t decode_kind(input vec_entry_t e);
      case ({e.line, e.pos})
         2'b01:   return VEC_MOVE;
         2'b10:   return VEC_DRAW;
         2'b11:   return VEC_END;
         default: return VEC_INVALID;
      endcase
   endfunction

endpackage

// File: rtl/vector_list_sequencer_if.sv
// Beam command channel from the sequencer to the line-drawing / XY-DAC stage.
interface vector_list_sequencer_if;
   import vector_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   logic [XY_WIDTH-1:0] cmd_x;
   logic [XY_WIDTH-1:0] cmd_y;
   logic                cmd_beam;
   logic                cmd_last;

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_beam, cmd_last,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_beam, cmd_last,
      output cmd_ready
   );

endinterface

// File: rtl/vector_list_sequencer.sv
// Walks a vector-list ROM from start_addr to its terminator and issues one
// beam command per entry over a valid/ready channel.
//
// state   | meaning
// S_IDLE  | waiting for start; rom_addr and cmd_* hold
// S_FETCH | rom_data for rom_addr is decoded and registered (one cycle)
// S_ISSUE | command presented, waiting for cmd_ready
module vector_list_sequencer
   import vector_pkg::*;
#(
   parameter int ADDRESSWIDTH = 6,
   parameter int DATAWIDTH    = 18,
   parameter int MAX_LEN      = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDRESSWIDTH-1:0] start_addr,
   output logic [ADDRESSWIDTH-1:0] rom_addr,
   input  logic [DATAWIDTH-1:0]    rom_data,
   vector_list_sequencer_if.master cmd,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int CNT_W = $clog2(MAX_LEN + 1);

   seq_state_t              r_state, w_state;
   logic [ADDRESSWIDTH-1:0] r_addr, w_addr;
   logic [CNT_W-1:0]        r_cnt, w_cnt;
   logic [XY_WIDTH-1:0]     r_x, w_x;
   logic [XY_WIDTH-1:0]     r_y, w_y;
   logic                    r_beam, w_beam;
   logic                    r_last, w_last;
   logic                    r_valid, w_valid;
   logic                    r_busy, w_busy;
   logic                    r_done, w_done;
   logic                    r_err, w_err;
   logic                    r_end, w_end;

   vec_entry_t w_entry;
   vec_kind_t  w_kind;
   logic       w_hs;

   assign w_entry = vec_entry_t'(rom_data);
   assign w_kind  = decode_kind(w_entry);
   assign w_hs    = r_valid && cmd.cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_beam  <= 1'b0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_end   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_addr  <= w_addr;
         r_cnt   <= w_cnt;
         r_x     <= w_x;
         r_y     <= w_y;
         r_beam  <= w_beam;
         r_last  <= w_last;
         r_valid <= w_valid;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_err   <= w_err;
         r_end   <= w_end;
      end
   end

   always_comb begin
      w_state = r_state;
      w_addr  = r_addr;
      w_cnt   = r_cnt;
      w_x     = r_x;
      w_y     = r_y;
      w_beam  = r_beam;
      w_last  = r_last;
      w_valid = r_valid;
      w_busy  = r_busy;
      w_err   = r_err;
      w_done  = 1'b0;
      w_end   = 1'b0;

      case (r_state)
         S_IDLE: begin
            // r_end marks the cycle a list finished; start is not taken then.
            if (start && !r_end) begin
               w_addr  = start_addr;
               w_cnt   = '0;
               w_busy  = 1'b1;
               w_err   = 1'b0;
               w_state = S_FETCH;
            end
         end

         S_FETCH: begin
            if (w_kind == VEC_INVALID) begin
               w_err   = 1'b1;
               w_busy  = 1'b0;
               w_end   = 1'b1;
               w_state = S_IDLE;
            end else begin
               w_x     = w_entry.x;
               w_y     = w_entry.y;
               w_beam  = (w_kind == VEC_DRAW);
               w_last  = (w_kind == VEC_END);
               w_valid = 1'b1;
               w_cnt   = r_cnt + CNT_W'(1);
               w_state = S_ISSUE;
            end
         end

         S_ISSUE: begin
            if (w_hs) begin
               w_valid = 1'b0;
               if (r_last) begin
                  w_done  = 1'b1;
                  w_busy  = 1'b0;
                  w_end   = 1'b1;
                  w_state = S_IDLE;
               end else if (r_cnt == CNT_W'(MAX_LEN) || (&r_addr)) begin
                  w_err   = 1'b1;
                  w_busy  = 1'b0;
                  w_end   = 1'b1;
                  w_state = S_IDLE;
               end else begin
                  w_addr  = r_addr + ADDRESSWIDTH'(1);
                  w_state = S_FETCH;
               end
            end
         end

         default: w_state = S_IDLE;
      endcase
   end

   assign rom_addr      = r_addr;
   assign cmd.cmd_valid = r_valid;
   assign cmd.cmd_x     = r_x;
   assign cmd.cmd_y     = r_y;
   assign cmd.cmd_beam  = r_beam;
   assign cmd.cmd_last  = r_last;
   assign busy          = r_busy;
   assign done          = r_done;
   assign err           = r_err;

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Bench for vector_list_sequencer: directed lists against a list-walk model.
module tb_vector_list_sequencer;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic       beam;
      logic       last;
   } exp_cmd_t;

   logic        clk;
   logic        rst_n;
   logic        start, start_l;
   logic [5:0]  start_addr, start_addr_l;
   logic [5:0]  rom_addr, rom_addr_l;
   logic [17:0] rom_data, rom_data_l;
   logic        busy, done, err;
   logic        busy_l, done_l, err_l;
   logic [17:0] rom [64];

   int          cyc;
   int          t0;
   int          n_cmp;
   int          n_err;
   int          hs_count;
   int          hs_cyc[$];
   bit          armed;
   bit          exp_err;
   exp_cmd_t    exp_q[$];

   vector_list_sequencer_if bus ();
   vector_list_sequencer_if lbus ();

   vector_list_sequencer #(.ADDRESSWIDTH(6), .DATAWIDTH(18), .MAX_LEN(64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .rom_addr(rom_addr), .rom_data(rom_data), .cmd(bus),
      .busy(busy), .done(done), .err(err)
   );

   vector_list_sequencer #(.ADDRESSWIDTH(6), .DATAWIDTH(18), .MAX_LEN(3)) dut_l (
      .clk(clk), .rst_n(rst_n), .start(start_l), .start_addr(start_addr_l),
      .rom_addr(rom_addr_l), .rom_data(rom_data_l), .cmd(lbus),
      .busy(busy_l), .done(done_l), .err(err_l)
   );

   assign rom_data   = rom[rom_addr];
   assign rom_data_l = rom[rom_addr_l];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [17:0] mk(input int x, input int y, input logic [1:0] k);
      logic [7:0] xb, yb;
      xb = x[7:0];
      yb = y[7:0];
      return {xb, yb, k};
   endfunction

   // Walk the ROM image the way the list format defines it.
   function automatic void build_list(input int sa, input int maxlen);
      int         a;
      int         n;
      logic [17:0] e;
      exp_cmd_t   c;
      a = sa;
      n = 0;
      exp_q.delete();
      exp_err = 1'b0;
      while (1) begin
         e = rom[a];
         if (e[1:0] == 2'b00) begin exp_err = 1'b1; break; end
         c.x    = e[17:10];
         c.y    = e[9:2];
         c.beam = (e[1:0] == 2'b10);
         c.last = (e[1:0] == 2'b11);
         exp_q.push_back(c);
         n++;
         if (c.last) break;
         if (n == maxlen) begin exp_err = 1'b1; break; end
         if (a == 63) begin exp_err = 1'b1; break; end
         a++;
      end
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   // Compare process: every cycle a command or done is visible.
   always @(negedge clk) begin
      if (armed) begin
         if (bus.cmd_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL cmd_unexpected: got x=%0d y=%0d beam=%0d last=%0d, expected no command",
                        bus.cmd_x, bus.cmd_y, bus.cmd_beam, bus.cmd_last);
            end else if ({bus.cmd_x, bus.cmd_y, bus.cmd_beam, bus.cmd_last} !==
                         {exp_q[0].x, exp_q[0].y, exp_q[0].beam, exp_q[0].last}) begin
               n_err++;
               $display("FAIL cmd_fields: got x=%0d y=%0d beam=%0d last=%0d, expected x=%0d y=%0d beam=%0d last=%0d",
                        bus.cmd_x, bus.cmd_y, bus.cmd_beam, bus.cmd_last,
                        exp_q[0].x, exp_q[0].y, exp_q[0].beam, exp_q[0].last);
            end
            if (bus.cmd_ready) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               hs_count++;
               hs_cyc.push_back(cyc - t0);
            end
         end
         if (done) begin
            n_cmp++;
            if (exp_q.size() != 0 || exp_err) begin
               n_err++;
               $display("FAIL done_early: got done with %0d commands outstanding, expected done only after full list",
                        exp_q.size());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_list(input logic [5:0] a);
      build_list(int'(a), 64);
      hs_count = 0;
      hs_cyc.delete();
      armed = 1'b1;
      start = 1'b1;
      start_addr = a;
      t0 = cyc;
   endtask

   task automatic wait_end(input int budget, input int stall_at, input int stall_n, input int mid_start,
                           output int end_cyc, output bit got_done, output bit got_err);
      int left;
      left = stall_n;
      end_cyc = -1;
      got_done = 1'b0;
      got_err = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         start = 1'b0;
         if (cyc - t0 == mid_start) begin
            start = 1'b1;
            start_addr = 6'd63;
         end
         bus.cmd_ready = 1'b1;
         if (bus.cmd_valid && hs_count == stall_at && left > 0) begin
            bus.cmd_ready = 1'b0;
            left--;
         end
         if (done) got_done = 1'b1;
         if (!busy && (done || err)) begin
            end_cyc = cyc - t0;
            got_err = err;
            break;
         end
      end
      bus.cmd_ready = 1'b1;
      start = 1'b0;
      if (end_cyc < 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL list_timeout: got no end within %0d cycles, expected done or err", budget);
      end
   endtask

   initial begin
      int  ec;
      bit  gd, ge;
      int  hs_l;
      bit  last_l, done_seen_l, ended_l;
      int  bp[6];

      n_cmp = 0;
      n_err = 0;
      armed = 1'b0;
      exp_err = 1'b0;
      hs_count = 0;
      t0 = 0;
      rst_n = 1'b0;
      start = 1'b0;
      start_l = 1'b0;
      start_addr = '0;
      start_addr_l = '0;
      bus.cmd_ready = 1'b1;
      lbus.cmd_ready = 1'b1;
      for (int i = 0; i < 64; i++) rom[i] = '0;
      rom[42] = mk(0, 255, 2'b01);
      rom[43] = mk(0, 0, 2'b10);
      rom[44] = mk(255, 0, 2'b10);
      rom[45] = mk(255, 255, 2'b10);
      rom[46] = mk(0, 255, 2'b10);
      rom[47] = mk(0, 255, 2'b11);
      rom[63] = mk(10, 20, 2'b01);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_outputs", {bus.cmd_valid, bus.cmd_x, bus.cmd_y, bus.cmd_beam, bus.cmd_last, busy, done, err}, 0);
      rst_n = 1'b1;
      tick();

      // Model pins.
      build_list(42, 64);
      chk("model_len", exp_q.size(), 6);
      chk("model_cmd1", {exp_q[1].x, exp_q[1].y, exp_q[1].beam, exp_q[1].last}, {8'd0, 8'd0, 1'b1, 1'b0});
      chk("model_cmd5", {exp_q[5].x, exp_q[5].y, exp_q[5].beam, exp_q[5].last}, {8'd0, 8'd255, 1'b0, 1'b1});
      build_list(42, 3);
      chk("model_maxlen", {exp_q.size(), 31'(exp_err)}, {32'd3, 31'd1});

      // End-screen walk with an ignored mid-list start and a start in the done cycle.
      start_list(6'd42);
      wait_end(60, -1, 0, 5, ec, gd, ge);
      chk("end_done_cycle", ec, 13);
      chk("end_done_seen", gd, 1);
      chk("end_err", ge, 0);
      chk("end_hs_count", hs_count, 6);
      for (int i = 0; i < 6; i++) begin
         if (i < hs_cyc.size()) chk("end_hs_cycle", hs_cyc[i], 2 + 2 * i);
      end
      start = 1'b1;
      start_addr = 6'd0;
      tick();
      start = 1'b0;
      chk("start_in_done_busy", busy, 0);
      chk("start_in_done_err", {done, err}, 0);
      repeat (2) tick();

      // Backpressure on the second command.
      start_list(6'd42);
      wait_end(60, 1, 3, -1, ec, gd, ge);
      chk("bp_done_cycle", ec, 16);
      chk("bp_hs_count", hs_count, 6);
      bp = '{2, 7, 9, 11, 13, 15};
      for (int i = 0; i < 6; i++) begin
         if (i < hs_cyc.size()) chk("bp_hs_cycle", hs_cyc[i], bp[i]);
      end
      repeat (2) tick();

      // Invalid entry, then recovery.
      start_list(6'd0);
      wait_end(20, -1, 0, -1, ec, gd, ge);
      chk("inv_err_cycle", ec, 2);
      chk("inv_err", {31'(ge), gd}, {31'd1, 1'b0});
      chk("inv_no_cmd", hs_count, 0);
      chk("inv_busy", busy, 0);
      repeat (2) tick();
      start_list(6'd42);
      tick();
      start = 1'b0;
      chk("recover_err_cleared", {busy, err}, 2'b10);
      wait_end(60, -1, 0, -1, ec, gd, ge);
      chk("recover_done_cycle", ec, 13);
      chk("recover_err", ge, exp_err);
      repeat (2) tick();

      // No wrap past the top of the ROM.
      start_list(6'd63);
      wait_end(20, -1, 0, -1, ec, gd, ge);
      chk("nowrap_end_cycle", ec, 3);
      chk("nowrap_err", ge, 1);
      chk("nowrap_hs", hs_count, 1);
      chk("nowrap_rom_addr", rom_addr, 63);
      repeat (2) tick();

      // Length limit on the MAX_LEN=3 instance.
      armed = 1'b0;
      hs_l = 0;
      last_l = 1'b0;
      done_seen_l = 1'b0;
      ended_l = 1'b0;
      start_l = 1'b1;
      start_addr_l = 6'd42;
      tick();
      start_l = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (lbus.cmd_valid) hs_l++;
         if (lbus.cmd_valid && lbus.cmd_last) last_l = 1'b1;
         if (done_l) done_seen_l = 1'b1;
         if (err_l && !busy_l) begin ended_l = 1'b1; break; end
      end
      chk("maxlen_ended", ended_l, 1);
      chk("maxlen_hs", hs_l, 3);
      chk("maxlen_err", err_l, 1);
      chk("maxlen_no_done_last", {done_seen_l, last_l}, 0);
      tick();

      // Reset while the third command is pending, then a fresh run.
      start_list(6'd42);
      ended_l = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         start = 1'b0;
         if (hs_count == 2 && bus.cmd_valid) begin ended_l = 1'b1; break; end
      end
      chk("rst_reached_cmd3", ended_l, 1);
      armed = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("midrst_rom_addr", rom_addr, 0);
      chk("midrst_outputs", {bus.cmd_valid, bus.cmd_x, bus.cmd_y, bus.cmd_beam, bus.cmd_last, busy, done, err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      start_list(6'd42);
      wait_end(60, -1, 0, -1, ec, gd, ge);
      chk("postrst_done_cycle", ec, 13);
      chk("postrst_hs", hs_count, 6);
      tick();
      armed = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vector_list_sequencer.md
Name: vector_list_sequencer

Overview:
- Walks one vector-list ROM image (end screen, title screen, etc.) from a start address to its terminator entry.
- Drives the ROM address each fetch and decodes each 18-bit entry {x[8], y[8], line, pos}.
- Issues one beam command per entry to the downstream line-drawing/XY-DAC stage over a valid/ready handshake.
- Sits directly between the screen ROMs and the vector drawer.

Parameters:
- ADDRESSWIDTH, 6, ROM address width; must match the attached ROM.
- DATAWIDTH, 18, ROM entry width: x[17:10], y[9:2], line[1], pos[0].
- MAX_LEN, 64, maximum number of entries issued per list before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run a list; ignored while busy
- start_addr  in  ADDRESSWIDTH  first ROM entry of the list, sampled with start
- rom_addr  out  ADDRESSWIDTH  address to ROM (combinational ROM, data valid same cycle)
- rom_data  in  DATAWIDTH  entry returned by ROM
- cmd_valid  out  1  command available
- cmd_ready  in  1  downstream accepts command
- cmd_x  out  8  target x
- cmd_y  out  8  target y
- cmd_beam  out  1  1 = draw line to target, 0 = move with beam off
- cmd_last  out  1  final command of the list
- busy  out  1  list in progress
- done  out  1  one-cycle pulse after last command is accepted
- err  out  1  sticky abort flag, cleared by the next accepted start

Behaviour:
- **Clock and reset:** one clock, clk; reset is asynchronous and active-low, rst_n.
- **Reset values:** all outputs and rom_addr = 0; state = IDLE; entry counter = 0.
- **Entry decode on {line,pos}:**
  - 01 = move: beam = 0, last = 0.
  - 10 = draw: beam = 1, last = 0.
  - 11 = terminator: emitted as a move to its coordinates with beam = 0, last = 1.
  - 00 = invalid (unprogrammed ROM default).
- **IDLE:** on start, load rom_addr <= start_addr, counter <= 0, busy <= 1, err <= 0, go to FETCH.
- **FETCH (exactly 1 cycle):** decode rom_data.
  - Invalid entry -> ERR path: err <= 1, busy <= 0, back to IDLE; no command is issued.
  - Otherwise register cmd_x/cmd_y/cmd_beam/cmd_last, set cmd_valid <= 1, counter += 1, go to ISSUE.
- **ISSUE:** cmd_valid stays high and all cmd_* stay stable until cmd_valid && cmd_ready. On handshake, cmd_valid <= 0, then:
  - cmd_last -> done <= 1 for one cycle, busy <= 0, go to IDLE.
  - else counter == MAX_LEN -> err <= 1, busy <= 0, go to IDLE.
  - else rom_addr is all-ones (no wrap allowed) -> err <= 1, busy <= 0, go to IDLE.
  - else rom_addr <= rom_addr + 1, go to FETCH.
- **Latency:** start at cycle 0 -> first cmd_valid at cycle 2. With cmd_ready held high, one command every 2 cycles.
- **done:** asserted the cycle after the last handshake.
- **Counter width:** $clog2(MAX_LEN+1).
- **rom_addr:** held constant outside FETCH/ISSUE transitions.
- **Simultaneous events:**
  - start during busy is ignored, including in the cycle done is asserted.
  - start is accepted again from the cycle after done/err.
- **Reset mid-list:** all outputs return to reset values immediately, with no pending command; the next start begins fresh.

Decomposition:
- Package vector_pkg:
  - XY_WIDTH = 8
  - packed struct vec_entry_t {x, y, line, pos}
  - enum vec_kind_t {VEC_INVALID, VEC_MOVE, VEC_DRAW, VEC_END}
  - function decode_kind()
  - sequencer state enum {S_IDLE, S_FETCH, S_ISSUE}
- No sub-module is needed; the decode is a package function. The ROM stays external.

Test Plan:
- **End-screen walk:** start_addr = 42, cmd_ready = 1, end-screen list loaded at 42..47. Expect 6 commands on cycles 2, 4, 6, 8, 10, 12:
  - (0,255,b0), (0,0,b1), (255,0,b1), (255,255,b1), (0,255,b1), (0,255,b0,last)
  - done on cycle 13, busy low from cycle 13, err = 0.
- **Backpressure:** same list, cmd_ready low for 3 cycles while the 2nd command is valid. Expect cmd_x/cmd_y/cmd_beam = (0,0,1) held stable, no skipped or duplicated command, done delayed by exactly 3 cycles.
- **Invalid entry:** start_addr = 0 (zero entry). Expect err = 1 at cycle 2, cmd_valid never asserted, busy = 0; a later start at 42 clears err and completes normally.
- **Length limit:** MAX_LEN = 3, start_addr = 42. Expect exactly 3 handshakes, then err = 1, no done, cmd_last never seen.
- **No wrap:** a move entry at address 63 with start_addr = 63. Expect one command, then err = 1 and rom_addr not wrapped to 0.
- **Reset and overlapping start:**
  - rst_n low while the 3rd command is pending -> all outputs 0 immediately.
  - start pulsed mid-list -> ignored, list output unchanged.
